// File: rtl/bus_client.sv
// Clocked endpoint for one dual-rail bus slot: transition-encodes a request onto tx, decodes the rx response.
// Response valid 3 edges after the last rx rail change; one request outstanding, response held until rsp_ready.
module bus_client #(
  parameter int INPUT   = 4,
  parameter int OUTPUT  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT-1:0]        req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUTPUT-1:0]       rsp_data,
  output logic [INPUT-1:0][1:0]   tx,
  input  logic [OUTPUT-1:0][1:0]  rx,
  output logic                    busy,
  output logic [1:0]              err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t                   r_state;
  logic [OUTPUT-1:0][1:0]   r_rx_meta;
  logic [OUTPUT-1:0][1:0]   r_rx_s;
  logic [OUTPUT-1:0][1:0]   r_rx_prev;
  logic [TW-1:0]            r_timer;
  logic [INPUT-1:0][1:0]    r_tx;
  logic [OUTPUT-1:0]        r_rsp_data;
  logic                     r_rsp_valid;
  logic                     r_req_ready;
  logic                     r_busy;
  logic [1:0]               r_err;

  logic                     w_rx_done;
  logic                     w_rx_bad;
  logic                     w_rx_change;
  logic [OUTPUT-1:0]        w_rsp_dec;
  logic [INPUT-1:0][1:0]    w_tx_next;

  // rx is asynchronous to clk; two-flop synchronizer, no reset so it keeps sampling during reset
  always_ff @(posedge clk) begin
    r_rx_meta <= rx;
    r_rx_s    <= r_rx_meta;
  end

  always_comb begin
    w_rx_done = 1'b1;
    w_rx_bad  = 1'b0;
    w_rsp_dec = '0;
    for (int i = 0; i < OUTPUT; i++) begin
      if (r_rx_s[i] == r_rx_prev[i])
        w_rx_done = 1'b0;
      if ((r_rx_s[i] ^ r_rx_prev[i]) == 2'b11)
        w_rx_bad = 1'b1;
      w_rsp_dec[i] = r_rx_s[i][1] ^ r_rx_prev[i][1];
    end
  end

  assign w_rx_change = (r_rx_s != r_rx_prev);

  always_comb begin
    w_tx_next = r_tx;
    for (int i = 0; i < INPUT; i++)
      w_tx_next[i] = r_tx[i] ^ (req_data[i] ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rx_prev   <= r_rx_s;
      r_timer     <= '0;
      r_tx        <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_change) begin
            r_err[0]  <= 1'b1;
            r_rx_prev <= r_rx_s;
          end
          // req_ready is already high here, so a simultaneous stray rail change must not drop the handshake
          if (req_valid) begin
            r_tx        <= w_tx_next;
            r_timer     <= '0;
            r_state     <= S_WAIT;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (w_rx_done) begin
            r_rsp_data  <= w_rsp_dec;
            r_rx_prev   <= r_rx_s;
            r_rsp_valid <= 1'b1;
            r_state     <= S_HOLD;
            if (w_rx_bad)
              r_err[0] <= 1'b1;
          end else if (r_timer == TMAX) begin
            r_err[1]    <= 1'b1;
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_HOLD: begin
          if (w_rx_change) begin
            r_err[0]  <= 1'b1;
            r_rx_prev <= r_rx_s;
          end
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: doc/bus_client.md
# bus_client

Clocked endpoint that occupies one user slot of the dual-rail arbitration bus. It accepts a request word on a synchronous valid/ready interface and transmits it onto the slot's `user_input` lines as a transition-encoded dual-rail codeword. It then waits for the completed response codeword on the slot's `user_output` lines, decodes it, and presents it on a synchronous valid/ready interface. This block bridges the clocked host logic into the asynchronous bus fabric.

## Interface
- `INPUT`, default `` `size `` (defs.svh): request word width, equal to the bus `INPUT`.
- `OUTPUT`, default `` `size ``: response word width, equal to the bus `OUTPUT`.
- `TIMEOUT`, default 1024: maximum cycles in WAIT before a timeout error; must be ≥ 4.

Ports:
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `req_valid` input 1: request word offered.
- `req_ready` output 1: block can accept a request.
- `req_data` input INPUT: request word.
- `rsp_valid` output 1: decoded response held.
- `rsp_ready` input 1: host consumes the response.
- `rsp_data` output OUTPUT: decoded response word.
- `tx` output Dual[INPUT]: drives bus `user_input[k]`.
- `rx` input Dual[OUTPUT]: from bus `user_output[k]`; asynchronous to `clk`.
- `busy` output 1: state is not IDLE.
- `err` output 2: sticky flags. Bit 0 is a protocol error; bit 1 is a timeout.

## Operation
- Encoding: each Dual element is {t, f}. A codeword is one transition per element. Data 1 toggles `t`; data 0 toggles `f`. An element is complete when exactly one rail differs from the previous sample.
- Input capture: `rx` passes through a 2-flop synchronizer to give `rx_s`. `rx_prev` holds the last accepted codeword.
- `rx_done` is true when every element of `rx_s` differs from `rx_prev` in at least one rail.
- `rx_bad` is true when any element differs in both rails.
- States:
  - IDLE: `req_ready`=1. On `req_valid`, register toggles into `tx` per `req_data` bit, clear the timer, and go to WAIT.
  - WAIT: increment the timer.
    - If `rx_done`: set `rsp_data[i]` = (`rx_s[i].t` != `rx_prev[i].t`), set `rx_prev` := `rx_s`, and go to HOLD. If `rx_bad` is also true, set `err[0]`.
    - Else if the timer reaches TIMEOUT-1: set `err[1]`, go to IDLE, and leave `rx_prev` unchanged.
  - HOLD: `rsp_valid`=1 and `rsp_data` is stable. On `rsp_ready`, go to IDLE.
- Any rail change seen in IDLE or HOLD (`rx_s` != `rx_prev`) sets `err[0]`. In that case, `rx_prev` := `rx_s` (resynchronise) and the state does not change.
- In WAIT, a partial change (some elements changed, not all) is legal skew. Keep waiting.
- `err` clears only on reset. Errors never block operation.
- There is at most one outstanding request. A second request is accepted only after its response is consumed or the request times out.

## Timing
- Reset values:
  - State IDLE; `req_ready`=1 from the first cycle after reset deasserts.
  - `rsp_valid`=0; `rsp_data`=0; `busy`=0; `err`=0.
  - `tx` all rails 0; timer 0.
- While `reset` is high, the synchronizer samples `rx` and `rx_prev` := `rx_s` every cycle.
- `reset` must be held ≥ 3 cycles and must overlap the bus reset.
- A request handshake in cycle n produces the `tx` toggle visible at the start of n+1, with `busy`=1 and `req_ready`=0 from n+1.
- If the last rail of the response changes before edge m, `rx_s` shows it after edge m+1. `rx_done` is evaluated in that cycle, and `rsp_valid` rises after edge m+2. Response latency is 3 edges.
- If `rsp_ready` is high when `rsp_valid` rises, the block returns to IDLE on the next edge. `req_ready`=1 in the following cycle, so there is no combinational ready-to-valid path.
- `rsp_ready` asserted before `rsp_valid` is ignored.
- A timeout on edge n gives IDLE, `req_ready`=1, and `err[1]`=1 after n. A late response then arrives as an IDLE-change and sets `err[0]`.
- Reset mid-WAIT or mid-HOLD abandons the transaction and resamples `rx` as the baseline.

## Test plan
- INPUT=OUTPUT=4: after reset, send `req_data`=4'b1010. Expect `tx` t-rails=1010 and f-rails=0101 on the next cycle, and `busy`=1.
- Model returns response 4'b0110 with per-element skew of 0–5 cycles. Expect `rsp_valid` exactly 3 edges after the last rail edge, `rsp_data`=0110, and `err`=0.
- Two back-to-back transactions: 4'b1111 then 4'b0000, with response 0011 then 1100. Expect each rail to toggle again, correct decode of both, and `rsp_ready` held low 5 cycles on the first without data change.
- TIMEOUT=8 with no response: expect `err`=2'b10 and `req_ready`=1 after 8 WAIT cycles. A later response toggle sets `err`=2'b11 and produces no `rsp_valid`.
- Response element 2 toggles both rails: expect `rsp_valid`, `err[0]`=1, and `rsp_data[2]`=1.
- Assert reset for 3 cycles during WAIT: expect all outputs at reset values, and the next request to complete normally.
